// File: rtl/rps_pkg.sv
// Shared encodings, state type and move helpers for the rock-paper-scissors referee.
package rps_pkg;

    localparam logic [2:0] ROCK     = 3'b110;
    localparam logic [2:0] PAPER    = 3'b101;
    localparam logic [2:0] SCISSORS = 3'b011;

    localparam logic [2:0] RES_P1  = 3'b000;
    localparam logic [2:0] RES_P2  = 3'b001;
    localparam logic [2:0] RES_TIE = 3'b010;
    localparam logic [2:0] RES_INV = 3'b100;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    typedef enum logic [1:0] {IDLE, PLAY, JUDGE, DONE} state_t;

    // A legal move has exactly one zero bit.
    function automatic logic move_legal(input logic [2:0] m);
        return (m == ROCK) || (m == PAPER) || (m == SCISSORS);
    endfunction

    function automatic logic move_beats(input logic [2:0] a, input logic [2:0] b);
        return ((a == ROCK)     && (b == SCISSORS)) ||
               ((a == PAPER)    && (b == ROCK))     ||
               ((a == SCISSORS) && (b == PAPER));
    endfunction

endpackage

// File: rtl/rps_round_judge.sv
// Combinational judge for one round: illegal moves first, then tie, then the win cycle.
module rps_round_judge
    import rps_pkg::*;
(
    input  logic [2:0] p1,
    input  logic [2:0] p2,
    output logic [2:0] result,
    output logic       p1_bad,
    output logic       p2_bad
);

    always_comb begin
        p1_bad = !move_legal(p1);
        p2_bad = !move_legal(p2);
        if (p1_bad || p2_bad) begin
            result = RES_INV;
        end else if (p1 == p2) begin
            result = RES_TIE;
        end else if (move_beats(p1, p2)) begin
            result = RES_P1;
        end else begin
            result = RES_P2;
        end
    end

endmodule

// File: rtl/rps_match_referee.sv
// Best-of-N referee: accepts round pairs, judges them, keeps scores and declares a winner.
module rps_match_referee
    import rps_pkg::*;
#(
    parameter int unsigned WIN_TARGET   = 3,
    parameter int unsigned MAX_ROUNDS   = 15,
    parameter int unsigned INVALID_MODE = 0,
    localparam int unsigned SCORE_W     = $clog2(MAX_ROUNDS + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               move_valid,
    output logic               move_ready,
    input  logic [2:0]         p1_move,
    input  logic [2:0]         p2_move,
    output logic               result_valid,
    output logic [2:0]         result,
    output logic [1:0]         round_invalid,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic [SCORE_W-1:0] round_cnt,
    output logic               match_done,
    output logic [1:0]         match_winner
);

    localparam logic [SCORE_W-1:0] WIN_V = SCORE_W'(WIN_TARGET);
    localparam logic [SCORE_W-1:0] MAX_V = SCORE_W'(MAX_ROUNDS);

    state_t             state;
    logic [2:0]         p1_q;
    logic [2:0]         p2_q;
    logic [2:0]         j_result;
    logic               p1_bad;
    logic               p2_bad;
    logic               p1_pt;
    logic               p2_pt;
    logic [SCORE_W-1:0] p1_nxt;
    logic [SCORE_W-1:0] p2_nxt;
    logic [SCORE_W-1:0] cnt_nxt;

    rps_round_judge u_judge (
        .p1     (p1_q),
        .p2     (p2_q),
        .result (j_result),
        .p1_bad (p1_bad),
        .p2_bad (p2_bad)
    );

    // Score and count values the JUDGE exit edge will commit; a lone illegal move may forfeit.
    always_comb begin
        p1_pt   = (j_result == RES_P1) || ((INVALID_MODE != 0) && p2_bad && !p1_bad);
        p2_pt   = (j_result == RES_P2) || ((INVALID_MODE != 0) && p1_bad && !p2_bad);
        p1_nxt  = p1_score + SCORE_W'(p1_pt);
        p2_nxt  = p2_score + SCORE_W'(p2_pt);
        cnt_nxt = round_cnt + SCORE_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            p1_q          <= 3'b000;
            p2_q          <= 3'b000;
            move_ready    <= 1'b0;
            result_valid  <= 1'b0;
            result        <= 3'b000;
            round_invalid <= 2'b00;
            p1_score      <= '0;
            p2_score      <= '0;
            round_cnt     <= '0;
            match_done    <= 1'b0;
            match_winner  <= WIN_NONE;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state        <= PLAY;
                        move_ready   <= 1'b1;
                        match_done   <= 1'b0;
                        p1_score     <= '0;
                        p2_score     <= '0;
                        round_cnt    <= '0;
                        match_winner <= WIN_NONE;
                    end
                end
                PLAY: begin
                    if (move_valid && move_ready) begin
                        p1_q       <= p1_move;
                        p2_q       <= p2_move;
                        move_ready <= 1'b0;
                        state      <= JUDGE;
                    end
                end
                JUDGE: begin
                    result        <= j_result;
                    round_invalid <= {p2_bad, p1_bad};
                    result_valid  <= 1'b1;
                    p1_score      <= p1_nxt;
                    p2_score      <= p2_nxt;
                    round_cnt     <= cnt_nxt;
                    if (p1_nxt == WIN_V) begin
                        state        <= DONE;
                        match_done   <= 1'b1;
                        match_winner <= WIN_P1;
                    end else if (p2_nxt == WIN_V) begin
                        state        <= DONE;
                        match_done   <= 1'b1;
                        match_winner <= WIN_P2;
                    end else if (cnt_nxt == MAX_V) begin
                        state        <= DONE;
                        match_done   <= 1'b1;
                        match_winner <= (p1_nxt > p2_nxt) ? WIN_P1 :
                                        (p2_nxt > p1_nxt) ? WIN_P2 : WIN_NONE;
                    end else begin
                        state      <= PLAY;
                        move_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
